// File: rtl/bp_pkg.sv
// bp_pkg: shared widths, update-entry type and FSM state names for the
// branch predictor update scheduler.
package bp_pkg;

  localparam int BP_IDX_W = 10;
  localparam int BP_BHR_W = 10;
  localparam int BP_PC_W  = 32;

  typedef struct packed {
    logic [BP_PC_W-1:0]  pc;
    logic [BP_BHR_W-1:0] bhr;
    logic                taken;
  } bp_upd_t;

  typedef enum logic [0:0] {
    BP_INIT = 1'b0,
    BP_RUN  = 1'b1
  } bp_state_e;

endpackage

// File: rtl/bp_update_sched_if.sv
// bp_update_sched_if: resolved-branch ports, flush, predictor update port and
// table-clear walk outputs of the update scheduler.
// With BP_UPD_STATS_EN defined, the update/taken statistics outputs are added.
interface bp_update_sched_if
  import bp_pkg::*;
#(
  parameter int PC_W  = BP_PC_W,
  parameter int BHR_W = BP_BHR_W,
  parameter int IDX_W = BP_IDX_W
);

  logic             rs0_valid;
  logic [PC_W-1:0]  rs0_pc;
  logic [BHR_W-1:0] rs0_bhr;
  logic             rs0_taken;
  logic             rs0_ready;
  logic             rs1_valid;
  logic [PC_W-1:0]  rs1_pc;
  logic [BHR_W-1:0] rs1_bhr;
  logic             rs1_taken;
  logic             rs1_ready;
  logic             flush;
  logic             update_en;
  logic [PC_W-1:0]  update_pc;
  logic [BHR_W-1:0] update_BHR;
  logic             branch_en;
  logic             init_en;
  logic [IDX_W-1:0] init_idx;
  logic             init_done;
`ifdef BP_UPD_STATS_EN
  logic [31:0]      stat_updates;
  logic [31:0]      stat_taken;
`endif

  modport master (
    output rs0_valid, rs0_pc, rs0_bhr, rs0_taken,
    output rs1_valid, rs1_pc, rs1_bhr, rs1_taken,
    output flush,
    input  rs0_ready, rs1_ready,
    input  update_en, update_pc, update_BHR, branch_en,
    input  init_en, init_idx, init_done
`ifdef BP_UPD_STATS_EN
    ,
    input  stat_updates, stat_taken
`endif
  );

  modport slave (
    input  rs0_valid, rs0_pc, rs0_bhr, rs0_taken,
    input  rs1_valid, rs1_pc, rs1_bhr, rs1_taken,
    input  flush,
    output rs0_ready, rs1_ready,
    output update_en, update_pc, update_BHR, branch_en,
    output init_en, init_idx, init_done
`ifdef BP_UPD_STATS_EN
    ,
    output stat_updates, stat_taken
`endif
  );

endinterface

// File: rtl/bp_upd_fifo.sv
// bp_upd_fifo: 2-write / 1-read FIFO of predictor updates. Slot 0 is written
// before slot 1 so program order survives a double push; flush empties the
// queue at the next edge and overrides any push or pop.
module bp_upd_fifo
  import bp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   push0,
  input  bp_upd_t                din0,
  input  logic                   push1,
  input  bp_upd_t                din1,
  input  logic                   pop,
  input  logic                   flush,
  output bp_upd_t                head,
  output logic [$clog2(DEPTH):0] count,
  output logic [$clog2(DEPTH):0] free
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  bp_upd_t            mem_q [DEPTH];
  bp_upd_t            mem_d [DEPTH];
  logic [PTR_W-1:0]   wptr_q, wptr_d;
  logic [PTR_W-1:0]   rptr_q, rptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   wptr1;

  // Next storage, pointers and occupancy; pointers wrap naturally modulo DEPTH.
  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    wptr1   = wptr_q + PTR_W'(push0);
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push0) mem_d[wptr_q] = din0;
      if (push1) mem_d[wptr1]  = din1;
      wptr_d  = wptr_q + PTR_W'(push0) + PTR_W'(push1);
      rptr_d  = rptr_q + PTR_W'(pop);
      count_d = count_q + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop);
    end
  end

  // Register storage and pointers; reset leaves the queue empty.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_q   <= '{default: '0};
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign head  = mem_q[rptr_q];
  assign count = count_q;
  assign free  = CNT_W'(DEPTH) - count_q;

endmodule

// File: rtl/bp_update_sched.sv
// bp_update_sched: walks the predictor table clear after reset, then accepts
// resolved-branch updates from two ports (port 0 older) into a small FIFO and
// drains it to the predictor one update per cycle.
// With BP_UPD_STATS_EN defined, saturating pop/taken counters are added.
module bp_update_sched
  import bp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IDX_W = BP_IDX_W,
  parameter int PC_W  = BP_PC_W,
  parameter int BHR_W = BP_BHR_W
) (
  input logic              clk,
  input logic              resetn,
  bp_update_sched_if.slave bus
);

  localparam int         CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [0:0] ST_INIT = BP_INIT;
  localparam logic [0:0] ST_RUN  = BP_RUN;

  logic [0:0]       state_q, state_d;
  logic             init_en_q, init_en_d;
  logic [IDX_W-1:0] init_idx_q, init_idx_d;
  logic             init_done_q, init_done_d;
  bp_upd_t          last_q, last_d;

  logic             run;
  logic             rs0_rdy, rs1_rdy;
  logic             push0, push1;
  logic             upd_en;
  bp_upd_t          entry0, entry1, head, upd_data;
  logic [CNT_W-1:0] fifo_count, fifo_free;

  // Table-clear walk: one idle edge arms init_en, then one index per cycle.
  always_comb begin
    state_d     = state_q;
    init_en_d   = init_en_q;
    init_idx_d  = init_idx_q;
    init_done_d = init_done_q;
    case (state_q)
      ST_INIT: begin
        if (!init_en_q) begin
          init_en_d = 1'b1;
        end else if (init_idx_q == {IDX_W{1'b1}}) begin
          state_d     = ST_RUN;
          init_en_d   = 1'b0;
          init_idx_d  = '0;
          init_done_d = 1'b1;
        end else begin
          init_idx_d = init_idx_q + 1'b1;
        end
      end
      default: begin
        init_en_d   = 1'b0;
        init_idx_d  = '0;
        init_done_d = 1'b1;
      end
    endcase
  end

  assign run = (state_q == ST_RUN);

  // Port 1 needs room for port 0 as well when port 0 is presenting, so it
  // can never overtake an older refused branch.
  assign rs0_rdy = run & ~bus.flush & (fifo_free >= CNT_W'(1));
  assign rs1_rdy = run & ~bus.flush &
                   (fifo_free >= (bus.rs0_valid ? CNT_W'(2) : CNT_W'(1)));
  assign push0   = bus.rs0_valid & rs0_rdy;
  assign push1   = bus.rs1_valid & rs1_rdy;
  assign upd_en  = run & (fifo_count != '0) & ~bus.flush;

  assign entry0 = '{pc: BP_PC_W'(bus.rs0_pc), bhr: BP_BHR_W'(bus.rs0_bhr), taken: bus.rs0_taken};
  assign entry1 = '{pc: BP_PC_W'(bus.rs1_pc), bhr: BP_BHR_W'(bus.rs1_bhr), taken: bus.rs1_taken};

  bp_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push0  (push0),
    .din0   (entry0),
    .push1  (push1),
    .din1   (entry1),
    .pop    (upd_en),
    .flush  (run & bus.flush),
    .head   (head),
    .count  (fifo_count),
    .free   (fifo_free)
  );

  // Data outputs show the head while updating and otherwise hold the last
  // update sent, so the predictor port never sees stale queue slots.
  always_comb begin
    upd_data = upd_en ? head : last_q;
    last_d   = upd_data;
  end

  // FSM, walk counter and held-output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_INIT;
      init_en_q   <= 1'b0;
      init_idx_q  <= '0;
      init_done_q <= 1'b0;
      last_q      <= '0;
    end else begin
      state_q     <= state_d;
      init_en_q   <= init_en_d;
      init_idx_q  <= init_idx_d;
      init_done_q <= init_done_d;
      last_q      <= last_d;
    end
  end

  assign bus.rs0_ready  = rs0_rdy;
  assign bus.rs1_ready  = rs1_rdy;
  assign bus.update_en  = upd_en;
  assign bus.update_pc  = PC_W'(upd_data.pc);
  assign bus.update_BHR = BHR_W'(upd_data.bhr);
  assign bus.branch_en  = upd_data.taken;
  assign bus.init_en    = init_en_q;
  assign bus.init_idx   = init_idx_q;
  assign bus.init_done  = init_done_q;

`ifdef BP_UPD_STATS_EN
  logic [31:0] stat_updates_q, stat_updates_d;
  logic [31:0] stat_taken_q, stat_taken_d;

  // Saturating counts of updates sent and of those that were taken.
  always_comb begin
    stat_updates_d = stat_updates_q;
    stat_taken_d   = stat_taken_q;
    if (upd_en && (stat_updates_q != 32'hFFFF_FFFF)) stat_updates_d = stat_updates_q + 32'd1;
    if (upd_en && head.taken && (stat_taken_q != 32'hFFFF_FFFF)) stat_taken_d = stat_taken_q + 32'd1;
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stat_updates_q <= '0;
      stat_taken_q   <= '0;
    end else begin
      stat_updates_q <= stat_updates_d;
      stat_taken_q   <= stat_taken_d;
    end
  end

  assign bus.stat_updates = stat_updates_q;
  assign bus.stat_taken   = stat_taken_q;
`endif

endmodule

// File: tb/tb_bp_update_sched.sv
// tb_bp_update_sched: scoreboard bench for bp_update_sched. The stimulus side
// keeps a queue model of the FIFO, predicts readies and accepted entries; a
// negedge monitor pops the queue whenever an update is due and compares.
// Define BP_UPD_STATS_EN to also check the statistics counters.
module tb_bp_update_sched;

  localparam int DEPTH = 4;
  localparam int IDX_W = 10;
  localparam int PC_W  = 32;
  localparam int BHR_W = 10;
  localparam int WALK  = 1 << IDX_W;

  typedef struct {
    logic [PC_W-1:0]  pc;
    logic [BHR_W-1:0] bhr;
    logic             taken;
  } ent_t;

  logic  clk = 1'b0;
  logic  resetn = 1'b0;
  int    tests = 0;
  int    fails = 0;
  ent_t  exp_q[$];
  ent_t  last_ent;
  bit    exp_upd_en = 1'b0;
  bit    mon_on = 1'b0;
  int    mdl_updates = 0;
  int    mdl_taken = 0;

  bp_update_sched_if #(.PC_W(PC_W), .BHR_W(BHR_W), .IDX_W(IDX_W)) bus ();

  bp_update_sched #(.DEPTH(DEPTH), .IDX_W(IDX_W), .PC_W(PC_W), .BHR_W(BHR_W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clearInputs();
    bus.rs0_valid = 1'b0; bus.rs0_pc = '0; bus.rs0_bhr = '0; bus.rs0_taken = 1'b0;
    bus.rs1_valid = 1'b0; bus.rs1_pc = '0; bus.rs1_bhr = '0; bus.rs1_taken = 1'b0;
    bus.flush = 1'b0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_init_en"},    32'(bus.init_en), 32'd0);
    checkOutput({tag, "_init_done"},  32'(bus.init_done), 32'd0);
    checkOutput({tag, "_init_idx"},   32'(bus.init_idx), 32'd0);
    checkOutput({tag, "_update_en"},  32'(bus.update_en), 32'd0);
    checkOutput({tag, "_update_pc"},  bus.update_pc, 32'd0);
    checkOutput({tag, "_update_BHR"}, 32'(bus.update_BHR), 32'd0);
    checkOutput({tag, "_branch_en"},  32'(bus.branch_en), 32'd0);
    checkOutput({tag, "_rs0_ready"},  32'(bus.rs0_ready), 32'd0);
    checkOutput({tag, "_rs1_ready"},  32'(bus.rs1_ready), 32'd0);
  endtask

  // Checks n walk cycles (index 0..n-1) while pushing and flushing, which
  // must all be ignored.
  task automatic walkCheck(input int n);
    int bad_en = 0, bad_idx = 0, bad_rdy = 0, bad_done = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      bus.rs0_valid = 1'b1;
      bus.rs1_valid = 1'b1;
      bus.flush = k[0];
      if (bus.init_en !== 1'b1) bad_en++;
      if (bus.init_idx !== k[IDX_W-1:0]) bad_idx++;
      if (bus.rs0_ready !== 1'b0 || bus.rs1_ready !== 1'b0) bad_rdy++;
      if (bus.init_done !== 1'b0) bad_done++;
    end
    checkOutput("walk_init_en_bad_cycles", 32'(bad_en), 32'd0);
    checkOutput("walk_init_idx_bad_cycles", 32'(bad_idx), 32'd0);
    checkOutput("walk_ready_bad_cycles", 32'(bad_rdy), 32'd0);
    checkOutput("walk_init_done_bad_cycles", 32'(bad_done), 32'd0);
  endtask

  task automatic fullWalk();
    walkCheck(WALK);
    clearInputs();
    @(posedge clk); #1;
    checkOutput("run_init_en", 32'(bus.init_en), 32'd0);
    checkOutput("run_init_done", 32'(bus.init_done), 32'd1);
    checkOutput("run_init_idx", 32'(bus.init_idx), 32'd0);
    exp_upd_en = 1'b0;
    mon_on = 1'b1;
  endtask

  // One RUN cycle: drive inputs, predict readies from the model occupancy
  // and queue whatever the model says is accepted.
  task automatic applyStimulus(input logic v0, input logic [PC_W-1:0] pc0, input logic [BHR_W-1:0] bhr0,
                               input logic t0, input logic v1, input logic [PC_W-1:0] pc1,
                               input logic [BHR_W-1:0] bhr1, input logic t1, input logic fl);
    int   pre;
    bit   r0, r1;
    ent_t e;
    @(posedge clk); #1;
    bus.rs0_valid = v0; bus.rs0_pc = pc0; bus.rs0_bhr = bhr0; bus.rs0_taken = t0;
    bus.rs1_valid = v1; bus.rs1_pc = pc1; bus.rs1_bhr = bhr1; bus.rs1_taken = t1;
    bus.flush = fl;
    #1;
    pre = exp_q.size();
    r0 = !fl && (DEPTH - pre) >= 1;
    r1 = !fl && (DEPTH - pre) >= (v0 ? 2 : 1);
    checkOutput("rs0_ready", 32'(bus.rs0_ready), 32'(r0));
    checkOutput("rs1_ready", 32'(bus.rs1_ready), 32'(r1));
    exp_upd_en = !fl && (pre > 0);
    if (fl) begin
      exp_q.delete();
    end else begin
      if (v0 && r0) begin e.pc = pc0; e.bhr = bhr0; e.taken = t0; exp_q.push_back(e); end
      if (v1 && r1) begin e.pc = pc1; e.bhr = bhr1; e.taken = t1; exp_q.push_back(e); end
    end
  endtask

  task automatic idle();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && exp_q.size() > 0; i++) idle();
    checkOutput("drain_left_entries", 32'(exp_q.size()), 32'd0);
    idle();
  endtask

  task automatic enterReset(input string tag);
    mon_on = 1'b0;
    resetn = 1'b0;
    #1;
    checkResetOutputs(tag);
    exp_q.delete();
    exp_upd_en = 1'b0;
    last_ent.pc = '0; last_ent.bhr = '0; last_ent.taken = 1'b0;
    mdl_updates = 0;
    mdl_taken = 0;
    clearInputs();
    @(negedge clk);
    resetn = 1'b1;
  endtask

  // Scoreboard monitor: every RUN cycle, compare the update port against
  // the model's decision and the oldest queued entry.
  always @(negedge clk) begin
    ent_t e;
    if (mon_on) begin
      checkOutput("update_en", 32'(bus.update_en), 32'(exp_upd_en));
      if (exp_upd_en && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("update_pc", bus.update_pc, e.pc);
        checkOutput("update_BHR", 32'(bus.update_BHR), 32'(e.bhr));
        checkOutput("branch_en", 32'(bus.branch_en), 32'(e.taken));
        last_ent = e;
        mdl_updates++;
        if (e.taken) mdl_taken++;
      end else begin
        checkOutput("hold_update_pc", bus.update_pc, last_ent.pc);
        checkOutput("hold_update_BHR", 32'(bus.update_BHR), 32'(last_ent.bhr));
        checkOutput("hold_branch_en", 32'(bus.branch_en), 32'(last_ent.taken));
      end
    end
  end

  initial begin
    clearInputs();
    last_ent.pc = '0; last_ent.bhr = '0; last_ent.taken = 1'b0;
    #3;
    checkResetOutputs("reset");
    @(negedge clk);
    resetn = 1'b1;
    #1;
    checkOutput("pre_walk_init_en", 32'(bus.init_en), 32'd0);
    fullWalk();

    // Two branches in one cycle drain in program order.
    applyStimulus(1'b1, 32'h1000, 10'h3, 1'b1, 1'b1, 32'h2000, 10'h5, 1'b0, 1'b0);
    idle(); idle(); idle();

    // Occupancy 3 leaves room for one: port 1 refused, then taken alone.
    applyStimulus(1'b1, 32'h3000, 10'h11, 1'b0, 1'b1, 32'h3004, 10'h12, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h3008, 10'h13, 1'b1, 1'b1, 32'h300C, 10'h14, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h3010, 10'h15, 1'b0, 1'b1, 32'h3014, 10'h16, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0,    10'h0,  1'b0, 1'b1, 32'h3014, 10'h16, 1'b1, 1'b0);
    drain();

    // Flush with three queued and fresh pushes offered: all discarded.
    applyStimulus(1'b1, 32'h5000, 10'h21, 1'b1, 1'b1, 32'h5004, 10'h22, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h5008, 10'h23, 1'b1, 1'b1, 32'h500C, 10'h24, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h5010, 10'h25, 1'b0, 1'b1, 32'h5014, 10'h26, 1'b1, 1'b1);
    idle(); idle();
    applyStimulus(1'b1, 32'h4000, 10'h7, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    drain();

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 9) < 7, $urandom, 10'($urandom), 1'($urandom),
                    $urandom_range(0, 9) < 7, $urandom, 10'($urandom), 1'($urandom),
                    $urandom_range(0, 15) == 0);
    end
    drain();
`ifdef BP_UPD_STATS_EN
    checkOutput("stat_updates_random", bus.stat_updates, 32'(mdl_updates));
    checkOutput("stat_taken_random", bus.stat_taken, 32'(mdl_taken));
`endif

    // Reset while draining two entries, then while the walk is at 500.
    applyStimulus(1'b1, 32'h6000, 10'h31, 1'b1, 1'b1, 32'h6004, 10'h32, 1'b1, 1'b0);
    idle();
    enterReset("reset_mid_drain");
    walkCheck(501);
    #1;
    enterReset("reset_mid_walk");
    fullWalk();

    // Five updates with taken pattern 1,0,1,1,0.
    applyStimulus(1'b1, 32'h7000, 10'h41, 1'b1, 1'b1, 32'h7004, 10'h42, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h7008, 10'h43, 1'b1, 1'b1, 32'h700C, 10'h44, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h7010, 10'h45, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    drain();
`ifdef BP_UPD_STATS_EN
    checkOutput("stat_updates_five", bus.stat_updates, 32'd5);
    checkOutput("stat_taken_three", bus.stat_taken, 32'd3);
`endif

    mon_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
